// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    localparam int MAX_W = 256;

    // Reverses the low w bits of d; bits at w and above come back as zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] d, input int w);
        logic [MAX_W-1:0] r;
        r = {<<{d}};
        return r >> (MAX_W - w);
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Valid/ready operand and result bus of the pipelined shifter.
interface pipelined_shifter_if
    import shifter_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 4
) ();
    localparam int LEVELS = $clog2(N);

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_data;
    logic [LEVELS-1:0] in_shamt;
    shift_op_t         in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/shift_level.sv
// One combinational right-shift level by AMT; rotate fill exists only with PIPELINED_SHIFTER_ROTATE_EN.
module shift_level
    import shifter_pkg::*;
#(
    parameter int N   = 32,
    parameter int AMT = 1
) (
    input  logic [N-1:0] i_data,
    input  logic         i_en,
    input  shift_op_t    i_op,
    output logic [N-1:0] o_data
);
    logic [AMT-1:0] w_fill;

    // SRA keeps bit N-1 equal to the original sign, so the current MSB is a valid fill source.
    always_comb begin
        w_fill = '0;
        case (i_op)
            SHIFT_SRA: w_fill = {AMT{i_data[N-1]}};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            SHIFT_ROR: w_fill = i_data[AMT-1:0];
`endif
            default:   w_fill = '0;
        endcase
        o_data = i_en ? N'({w_fill, i_data} >> AMT) : i_data;
    end
endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, ROR when PIPELINED_SHIFTER_ROTATE_EN is defined)
// with valid/ready on both sides; SLL runs as reverse / shift right / reverse.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int N         = 32,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_shifter_if.slave bus
);
    localparam int LEVELS = $clog2(N);
    localparam int LAT    = (LEVELS + REG_EVERY - 1) / REG_EVERY;

    logic              r_valid [LAT];
    logic [N-1:0]      r_data  [LAT];
    logic [LEVELS-1:0] r_shamt [LAT];
    shift_op_t         r_op    [LAT];
    logic [TAG_W-1:0]  r_tag   [LAT];

    logic              w_adv       [LAT];
    logic              w_src_valid [LAT];
    logic [TAG_W-1:0]  w_src_tag   [LAT];

    logic [N-1:0]      w_in_data;
    logic [N-1:0]      w_lvl_in    [LEVELS];
    logic [N-1:0]      w_lvl_out   [LEVELS];
    logic [LEVELS-1:0] w_lvl_shamt [LEVELS];
    shift_op_t         w_lvl_op    [LEVELS];

    assign w_in_data = (bus.in_op == SHIFT_SLL) ? N'(bit_reverse(MAX_W'(bus.in_data), N))
                                                : bus.in_data;

    genvar gi;
    // Level chain: the first level of each stage reads the input or the previous slot.
    for (gi = 0; gi < LEVELS; gi++) begin : g_level
        localparam int STG = gi / REG_EVERY;
        if (gi % REG_EVERY == 0) begin : g_head
            if (STG == 0) begin : g_from_in
                assign w_lvl_in[gi]    = w_in_data;
                assign w_lvl_shamt[gi] = bus.in_shamt;
                assign w_lvl_op[gi]    = bus.in_op;
            end else begin : g_from_slot
                assign w_lvl_in[gi]    = r_data[STG-1];
                assign w_lvl_shamt[gi] = r_shamt[STG-1];
                assign w_lvl_op[gi]    = r_op[STG-1];
            end
        end else begin : g_chain
            assign w_lvl_in[gi]    = w_lvl_out[gi-1];
            assign w_lvl_shamt[gi] = w_lvl_shamt[gi-1];
            assign w_lvl_op[gi]    = w_lvl_op[gi-1];
        end

        shift_level #(.N(N), .AMT(1 << gi)) u_level (
            .i_data (w_lvl_in[gi]),
            .i_en   (w_lvl_shamt[gi][gi]),
            .i_op   (w_lvl_op[gi]),
            .o_data (w_lvl_out[gi])
        );
    end

    for (gi = 0; gi < LAT; gi++) begin : g_slot
        localparam int LAST = ((gi + 1) * REG_EVERY > LEVELS) ? LEVELS - 1 : (gi + 1) * REG_EVERY - 1;

        if (gi == 0) begin : g_src_in
            assign w_src_valid[gi] = bus.in_valid;
            assign w_src_tag[gi]   = bus.in_tag;
        end else begin : g_src_slot
            assign w_src_valid[gi] = r_valid[gi-1];
            assign w_src_tag[gi]   = r_tag[gi-1];
        end

        // Combinational ready chain: a slot moves if it is empty or its successor moves.
        if (gi == LAT - 1) begin : g_adv_last
            assign w_adv[gi] = !r_valid[gi] || bus.out_ready;
        end else begin : g_adv_mid
            assign w_adv[gi] = !r_valid[gi] || w_adv[gi+1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[gi] <= 1'b0;
                r_data[gi]  <= '0;
                r_shamt[gi] <= '0;
                r_op[gi]    <= SHIFT_SLL;
                r_tag[gi]   <= '0;
            end else if (w_adv[gi]) begin
                r_valid[gi] <= w_src_valid[gi];
                if (w_src_valid[gi]) begin
                    r_data[gi]  <= w_lvl_out[LAST];
                    r_shamt[gi] <= w_lvl_shamt[LAST];
                    r_op[gi]    <= w_lvl_op[LAST];
                    r_tag[gi]   <= w_src_tag[gi];
                end
            end
        end
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_valid[LAT-1];
    assign bus.out_tag   = r_tag[LAT-1];
    assign bus.out_data  = (r_op[LAT-1] == SHIFT_SLL) ? N'(bit_reverse(MAX_W'(r_data[LAT-1]), N))
                                                      : r_data[LAT-1];
endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: 32-bit/LAT=5 instance and 8-bit/REG_EVERY=3 (LAT=1) instance.
module tb_pipelined_shifter;
    import shifter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_shifter_if #(.N(32), .TAG_W(4)) bus ();
    pipelined_shifter_if #(.N(8),  .TAG_W(4)) bus8 ();

    pipelined_shifter #(.N(32), .REG_EVERY(1), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    pipelined_shifter #(.N(8),  .REG_EVERY(3), .TAG_W(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  op;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  tag;
    } exp_t;

`ifdef PIPELINED_SHIFTER_ROTATE_EN
    localparam logic [31:0] EXP_OP3_32 = 32'h1000_000F;
    localparam logic [31:0] EXP_OP3_8  = 32'h0000_001F;
`else
    localparam logic [31:0] EXP_OP3_32 = 32'h0000_000F;
    localparam logic [31:0] EXP_OP3_8  = 32'h0000_000F;
`endif

    exp_t q[$];
    exp_t q8[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_out = 0;
    bit   saw_stall = 1'b0;
    bit   rand_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Independent reference: plain shifts on a width-n value.
    function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic [1:0] op, input int n);
        logic [63:0] m, x, sx, r;
        m = (64'd1 << n) - 64'd1;
        x = {32'd0, d} & m;
        case (op)
            2'd0: r = (x << s) & m;
            2'd1: r = x >> s;
            2'd2: begin
                sx = x;
                if (x[n-1]) sx = x | ~m;
                r = ($signed(sx) >>> s) & m;
            end
            default: begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
                r = ((x >> s) | (x << (n - s))) & m;
`else
                r = x >> s;
`endif
            end
        endcase
        return r[31:0];
    endfunction

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                        input logic [3:0] tag, input logic [31:0] exp);
        int   n;
        exp_t e;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_op    = shift_op_t'(op);
        bus.in_tag   = tag;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (bus.in_ready) begin
            e.d = exp;
            e.tag = tag;
            q.push_back(e);
            $display("in  tag=%0d op=%0d shamt=%0d data=%h", tag, op, s, d);
        end else begin
            n_vec++;
            n_bad++;
            $display("FAIL in_ready_timeout: got in_ready 0 for 100 cycles, expected 1");
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] op,
                         input logic [3:0] tag, input logic [31:0] exp);
        int   n;
        exp_t e;
        n = 0;
        bus8.in_valid = 1'b1;
        bus8.in_data  = d;
        bus8.in_shamt = s;
        bus8.in_op    = shift_op_t'(op);
        bus8.in_tag   = tag;
        forever begin
            @(negedge clk);
            if (bus8.in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (bus8.in_ready) begin
            e.d = exp;
            e.tag = tag;
            q8.push_back(e);
        end else begin
            n_vec++;
            n_bad++;
            $display("FAIL in_ready8_timeout: got in_ready 0 for 100 cycles, expected 1");
        end
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0 && q8.size() == 0) break;
            @(negedge clk);
        end
        check("drain32", 64'(q.size()), 64'd0);
        check("drain8", 64'(q8.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        q.delete();
        q8.delete();
        #1 rst = 1'b0;
    endtask

    // Output monitors: pop and compare on each output transfer, check hold stability.
    initial begin : mon32
        exp_t        e;
        logic [35:0] last_hold;
        bit          holding;
        holding = 1'b0;
        last_hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding = 1'b0;
            end else begin
                if (bus.in_valid && !bus.in_ready && !bus.out_ready) saw_stall = 1'b1;
                if (bus.out_valid) begin
                    if (holding) check("hold_stable", 64'({bus.out_data, bus.out_tag}), 64'(last_hold));
                    if (bus.out_ready) begin
                        holding = 1'b0;
                        n_out++;
                        if (q.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL spurious_out: got tag %0d data %h, expected no output",
                                     bus.out_tag, bus.out_data);
                        end else begin
                            e = q.pop_front();
                            $display("out tag=%0d data=%h exp=%h", bus.out_tag, bus.out_data, e.d);
                            check("result32", 64'({bus.out_data, bus.out_tag}), 64'({e.d, e.tag}));
                        end
                    end else begin
                        holding = 1'b1;
                        last_hold = {bus.out_data, bus.out_tag};
                    end
                end else begin
                    holding = 1'b0;
                end
            end
        end
    end

    initial begin : mon8
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus8.out_valid && bus8.out_ready) begin
                if (q8.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_out8: got tag %0d data %h, expected no output",
                             bus8.out_tag, bus8.out_data);
                end else begin
                    e = q8.pop_front();
                    $display("out8 tag=%0d data=%h exp=%h", bus8.out_tag, bus8.out_data, e.d[7:0]);
                    check("result8", 64'({bus8.out_data, bus8.out_tag}), 64'({e.d[7:0], e.tag}));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    vec_t tbl[12];

    initial begin : main
        int n_before;
        logic [31:0] rd;
        logic [4:0]  rs;
        logic [1:0]  rop;

        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_shamt = '0;  bus.in_op = SHIFT_SLL;
        bus.in_tag = '0;      bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_shamt = '0; bus8.in_op = SHIFT_SLL;
        bus8.in_tag = '0;     bus8.out_ready = 1'b1;

        tbl[0]  = '{32'h8000_0000, 5'd4,  2'd2, 4'd3,  32'hF800_0000};
        tbl[1]  = '{32'h8000_0000, 5'd4,  2'd1, 4'd4,  32'h0800_0000};
        tbl[2]  = '{32'h0000_0001, 5'd31, 2'd0, 4'd5,  32'h8000_0000};
        tbl[3]  = '{32'hDEAD_BEEF, 5'd0,  2'd0, 4'd6,  32'hDEAD_BEEF};
        tbl[4]  = '{32'hDEAD_BEEF, 5'd0,  2'd1, 4'd7,  32'hDEAD_BEEF};
        tbl[5]  = '{32'hDEAD_BEEF, 5'd0,  2'd2, 4'd8,  32'hDEAD_BEEF};
        tbl[6]  = '{32'hDEAD_BEEF, 5'd0,  2'd3, 4'd9,  32'hDEAD_BEEF};
        tbl[7]  = '{32'h0000_00F1, 5'd4,  2'd3, 4'd10, EXP_OP3_32};
        tbl[8]  = '{32'h8000_0000, 5'd31, 2'd2, 4'd11, 32'hFFFF_FFFF};
        tbl[9]  = '{32'h8000_0000, 5'd31, 2'd1, 4'd12, 32'h0000_0001};
        tbl[10] = '{32'hDEAD_BEEF, 5'd4,  2'd0, 4'd13, 32'hEADB_EEF0};
        tbl[11] = '{32'h7000_0000, 5'd4,  2'd2, 4'd14, 32'h0700_0000};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_tag",   64'(bus.out_tag),   64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst8_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst8_in_ready",  64'(bus8.in_ready),  64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back to back
        for (int i = 0; i < 12; i++) send(tbl[i].d, tbl[i].s, tbl[i].op, tbl[i].tag, tbl[i].exp);
        wait_empty();

        // Stream of 8 with a 5-cycle output stall mid-stream
        n_before = n_out;
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    rd = $urandom;
                    rs = 5'($urandom_range(0, 31));
                    rop = 2'($urandom_range(0, 3));
                    send(rd, rs, rop, 4'(t), model(rd, int'(rs), rop, 32));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_empty();
        check("stall_seen", 64'(saw_stall), 64'd1);
        check("stream_count", 64'(n_out - n_before), 64'd8);

        // Reset with ops in flight on both instances
        bus.out_ready = 1'b0;
        bus8.out_ready = 1'b0;
        send8(8'h80, 3'd7, 2'd2, 4'd1, 32'hFF);
        for (int t = 0; t < 3; t++) send(32'h1234_5678, 5'(t), 2'd1, 4'(t), 32'h0);
        do_reset();
        bus.out_ready = 1'b1;
        bus8.out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("flush_out_valid",  64'(bus.out_valid),  64'd0);
            check("flush8_out_valid", 64'(bus8.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send8(8'h80, 3'd7, 2'd2, 4'd2, 32'hFF);
        send8(8'h01, 3'd7, 2'd0, 4'd3, 32'h80);
        send8(8'hF1, 3'd4, 2'd3, 4'd4, EXP_OP3_8);
        send8(8'hB5, 3'd0, 2'd2, 4'd5, 32'hB5);
        send(32'h0000_0001, 5'd31, 2'd0, 4'd6, 32'h8000_0000);
        send(32'h8000_0000, 5'd4,  2'd2, 4'd7, 32'hF800_0000);
        wait_empty();

        // Random scoreboard run with random out_ready
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    rd = $urandom;
                    rs = 5'($urandom_range(0, 31));
                    rop = 2'($urandom_range(0, 3));
                    send(rd, rs, rop, 4'(i), model(rd, int'(rs), rop, 32));
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
